// File: rtl/fsm_sym_packer_if.sv
// Symbol-in / word-out handshake bundle for fsm_sym_packer.
// master is the packer side, slave is the producer/consumer side.
interface fsm_sym_packer_if #(
    parameter int WORD_W = 8
);
    logic              sym_valid;
    logic [1:0]        sym;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (
        input  sym_valid, sym, out_ready,
        output out_valid, out_data
    );

    modport slave (
        output sym_valid, sym, out_ready,
        input  out_valid, out_data
    );
endinterface

// File: rtl/fsm_sym_packer.sv
// Packs 2-bit FSM symbols LSB-first into words, buffers them in a FIFO
// and presents them on a valid/ready port with a registered head.
module fsm_sym_packer #(
    parameter int SYMS  = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    fsm_sym_packer_if.master bus,
    output logic             ovf,
    output logic [CNT_W-1:0] word_cnt,
    output logic             busy
);
    localparam int WORD_W = 2 * SYMS;
    localparam int IW     = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_n;
    logic [IW-1:0]     idx, idx_n;
    logic [WORD_W-1:0] sreg, sreg_n, word;
    logic              push_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            idx   <= '0;
            sreg  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            sreg  <= sreg_n;
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        sreg_n   = sreg;
        push_req = 1'b0;
        word     = sreg;
        word[{idx, 1'b0} +: 2] = bus.sym;
        if (clr) begin
            state_n = IDLE;
            idx_n   = '0;
            sreg_n  = '0;
        end else if (bus.sym_valid) begin
            unique case (state)
                IDLE: begin
                    sreg_n  = WORD_W'(bus.sym);
                    idx_n   = IW'(1);
                    state_n = FILL;
                end
                FILL: begin
                    if (idx == IW'(SYMS - 1)) begin
                        push_req = 1'b1;
                        idx_n    = '0;
                        sreg_n   = '0;
                        state_n  = IDLE;
                    end else begin
                        sreg_n = word;
                        idx_n  = idx + IW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state == FILL);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, rd_nx, used, rem;
    logic              full, pop, push, drop;

    assign used  = wr_ptr - rd_ptr;
    assign full  = (used == (AW + 1)'(DEPTH));
    assign pop   = bus.out_valid && bus.out_ready;
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && !push;
    assign rd_nx = rd_ptr + {{AW{1'b0}}, pop};
    // The head register lags storage by one edge, so a word pushed now
    // is presented on the following edge.
    assign rem   = used - {{AW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr[AW-1:0]] <= word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            ovf           <= 1'b0;
            word_cnt      <= '0;
        end else if (clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            ovf           <= 1'b0;
            word_cnt      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            rd_ptr        <= rd_nx;
            bus.out_valid <= (rem != '0);
            if (rem != '0)
                bus.out_data <= mem[rd_nx[AW-1:0]];
            if (drop)
                ovf <= 1'b1;
            if (push && !(&word_cnt))
                word_cnt <= word_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fsm_sym_packer.sv
// Randomized self-checking bench for fsm_sym_packer against a
// queue-based word model.
module tb_fsm_sym_packer;
    localparam int SYMS   = 4;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 16;
    localparam int WORD_W = 2 * SYMS;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic             ovf;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    fsm_sym_packer_if #(.WORD_W(WORD_W)) bus();

    fsm_sym_packer #(
        .SYMS(SYMS), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus),
        .ovf(ovf), .word_cnt(word_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int                part[$];
    logic [WORD_W-1:0] fq[$];
    logic              m_valid;
    logic [WORD_W-1:0] m_data;
    logic              m_ovf;
    logic [CNT_W-1:0]  m_cnt;

    function automatic void model_reset();
        part.delete();
        fq.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
    endfunction

    function automatic void model_step(bit sv, bit [1:0] s, bit rdy, bit c);
        bit                pop, req;
        int                pre;
        logic [WORD_W-1:0] w;
        if (c) begin
            model_reset();
            return;
        end
        pop = m_valid && rdy;
        pre = fq.size();
        req = 1'b0;
        w   = '0;
        if (sv) begin
            part.push_back(int'(s));
            if (part.size() == SYMS) begin
                for (int i = 0; i < SYMS; i++)
                    w = w | (WORD_W'(part[i]) << (2 * i));
                part.delete();
                req = 1'b1;
            end
        end
        if (pop)
            void'(fq.pop_front());
        m_valid = (fq.size() > 0);
        if (m_valid)
            m_data = fq[0];
        if (req) begin
            if (pre < DEPTH || pop) begin
                fq.push_back(w);
                if (m_cnt != '1)
                    m_cnt = m_cnt + 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endfunction

    task automatic cyc(input bit sv, input bit [1:0] s,
                       input bit rdy, input bit c);
        bus.sym_valid = sv;
        bus.sym       = s;
        bus.out_ready = rdy;
        clr           = c;
        @(posedge clk);
        model_step(sv, s, rdy, c);
        #1;
    endtask

    function automatic bit [1:0] rsym();
        return 2'($urandom_range(3));
    endfunction

    task automatic test_reset();
        #12;
        total++;
        if ({bus.out_valid, bus.out_data, ovf, word_cnt, busy} !== '0)
            $display("FAIL reset_vals got v=%b d=%h o=%b c=%0d b=%b want 0",
                     bus.out_valid, bus.out_data, ovf, word_cnt, busy);
        else passed++;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        cyc(1, 2'd1, 1, 0);
        cyc(1, 2'd2, 1, 0);
        cyc(1, 2'd3, 1, 0);
        total++;
        if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy);
        else passed++;
        cyc(1, 2'd0, 1, 0);
        total++;
        if ({busy, bus.out_valid} !== 2'b00)
            $display("FAIL basic_last got busy=%b v=%b want 0 0", busy, bus.out_valid);
        else passed++;
        cyc(0, rsym(), 1, 0);
        total++;
        if ({bus.out_valid, bus.out_data, word_cnt} !== {1'b1, 8'h39, 16'd1})
            $display("FAIL basic_word got v=%b d=%h c=%0d want 1 39 1",
                     bus.out_valid, bus.out_data, word_cnt);
        else passed++;
        cyc(0, rsym(), 1, 0);
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL basic_pop got v=%b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_gaps();
        bit [1:0] arr [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        cyc(0, 2'd0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, arr[i], 0, 0);
            total++;
            if (busy !== (i % 4 != 3))
                $display("FAIL gaps_busy i=%0d got %b want %b", i, busy, i % 4 != 3);
            else passed++;
            cyc(0, rsym(), 0, 0);
            total++;
            if (busy !== (i % 4 != 3))
                $display("FAIL gaps_busy_idle i=%0d got %b want %b", i, busy, i % 4 != 3);
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.out_valid, bus.out_data, ovf} !== {1'b1, 8'h39, 1'b0})
                $display("FAIL gaps_hold got v=%b d=%h o=%b want 1 39 0",
                         bus.out_valid, bus.out_data, ovf);
            else passed++;
            cyc(0, rsym(), 0, 0);
        end
        cyc(0, 2'd0, 1, 0);
        total++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'he4})
            $display("FAIL gaps_second got v=%b d=%h want 1 e4", bus.out_valid, bus.out_data);
        else passed++;
        cyc(0, 2'd0, 1, 0);
        total++;
        if (bus.out_valid !== 1'b0)
            $display("FAIL gaps_empty got v=%b want 0", bus.out_valid);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] wexp [5];
        bit [1:0]   s;
        int         n = 0;
        cyc(0, 2'd0, 0, 1);
        for (int w = 0; w < 5; w++) begin
            wexp[w] = '0;
            for (int k = 0; k < 4; k++) begin
                s = rsym();
                wexp[w] = wexp[w] | (8'(s) << (2 * k));
                cyc(1, s, 0, 0);
            end
        end
        cyc(0, 2'd0, 0, 0);
        total++;
        if ({ovf, word_cnt} !== {1'b1, 16'd4})
            $display("FAIL ovf_flag got o=%b c=%0d want 1 4", ovf, word_cnt);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid === 1'b1) begin
                total++;
                if (n > 3 || bus.out_data !== wexp[n])
                    $display("FAIL ovf_drain n=%0d got %h want %h", n, bus.out_data,
                             wexp[n > 3 ? 3 : n]);
                else passed++;
                n++;
            end
            cyc(0, 2'd0, 1, 0);
        end
        total++;
        if (n !== 4) $display("FAIL ovf_count got %0d words want 4", n);
        else passed++;
    endtask

    task automatic test_full_pushpop();
        logic [7:0] wexp [5];
        bit [1:0]   s;
        int         n = 1;
        cyc(0, 2'd0, 0, 1);
        for (int w = 0; w < 5; w++) begin
            wexp[w] = '0;
            for (int k = 0; k < 4; k++) begin
                s = rsym();
                wexp[w] = wexp[w] | (8'(s) << (2 * k));
                cyc(1, s, (w == 4 && k == 3), 0);
            end
        end
        total++;
        if ({ovf, word_cnt} !== {1'b0, 16'd5})
            $display("FAIL full_pp got o=%b c=%0d want 0 5", ovf, word_cnt);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid === 1'b1) begin
                total++;
                if (n > 4 || bus.out_data !== wexp[n])
                    $display("FAIL full_drain n=%0d got %h want %h", n, bus.out_data,
                             wexp[n > 4 ? 4 : n]);
                else passed++;
                n++;
            end
            cyc(0, 2'd0, 1, 0);
        end
        total++;
        if (n !== 5) $display("FAIL full_occupancy got %0d words want 4", n - 1);
        else passed++;
    endtask

    task automatic test_clr();
        cyc(0, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++) cyc(1, rsym(), 0, 0);
        cyc(1, 2'd3, 0, 0);
        cyc(1, 2'd3, 0, 0);
        total++;
        if ({busy, bus.out_valid} !== 2'b11)
            $display("FAIL clr_pre got busy=%b v=%b want 1 1", busy, bus.out_valid);
        else passed++;
        cyc(1, 2'd2, 1, 1);
        total++;
        if ({busy, bus.out_valid, ovf, word_cnt} !== '0)
            $display("FAIL clr_vals got b=%b v=%b o=%b c=%0d want 0",
                     busy, bus.out_valid, ovf, word_cnt);
        else passed++;
        cyc(1, 2'd2, 0, 0);
        cyc(1, 2'd1, 0, 0);
        cyc(1, 2'd0, 0, 0);
        cyc(1, 2'd3, 0, 0);
        cyc(0, 2'd0, 0, 0);
        total++;
        if ({bus.out_valid, bus.out_data, word_cnt} !== {1'b1, 8'hc6, 16'd1})
            $display("FAIL clr_fresh got v=%b d=%h c=%0d want 1 c6 1",
                     bus.out_valid, bus.out_data, word_cnt);
        else passed++;
    endtask

    task automatic test_rst();
        cyc(0, 2'd0, 0, 1);
        for (int k = 0; k < 10; k++) cyc(1, rsym(), 0, 0);
        total++;
        if ({busy, bus.out_valid, word_cnt} !== {1'b1, 1'b1, 16'd2})
            $display("FAIL rst_pre got b=%b v=%b c=%0d want 1 1 2",
                     busy, bus.out_valid, word_cnt);
        else passed++;
        bus.sym_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_data, ovf, word_cnt, busy} !== '0)
            $display("FAIL rst_async got v=%b d=%h o=%b c=%0d b=%b want 0",
                     bus.out_valid, bus.out_data, ovf, word_cnt, busy);
        else passed++;
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        cyc(1, 2'd0, 0, 0);
        cyc(1, 2'd3, 0, 0);
        cyc(1, 2'd1, 0, 0);
        cyc(1, 2'd2, 0, 0);
        cyc(0, 2'd0, 0, 0);
        total++;
        if ({bus.out_valid, bus.out_data, word_cnt, busy} !== {1'b1, 8'h9c, 16'd1, 1'b0})
            $display("FAIL rst_after got v=%b d=%h c=%0d b=%b want 1 9c 1 0",
                     bus.out_valid, bus.out_data, word_cnt, busy);
        else passed++;
    endtask

    task automatic test_random();
        bit sv, rdy, c;
        cyc(0, 2'd0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            sv  = ($urandom_range(3) != 0);
            rdy = (i % 120 < 60) ? 1'b0 : 1'($urandom_range(1));
            c   = ($urandom_range(99) == 0);
            cyc(sv, rsym(), rdy, c);
            total++;
            if ({bus.out_valid, bus.out_data, ovf, word_cnt, busy} !==
                {m_valid, m_data, m_ovf, m_cnt, part.size() != 0})
                $display("FAIL rand i=%0d got v=%b d=%h o=%b c=%0d b=%b want %b %h %b %0d %b",
                         i, bus.out_valid, bus.out_data, ovf, word_cnt, busy,
                         m_valid, m_data, m_ovf, m_cnt, part.size() != 0);
            else passed++;
        end
    endtask

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym       = 2'd0;
        bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_overflow();
        test_full_pushpop();
        test_clr();
        test_rst();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
